i2s_serial_rx: RTL and testbench

- Receive-side I2S master: generates `bclk`/`lrclk` from the 12 MHz system clock and shifts in 24-bit ADC samples from the codec.
- Presents each left/right pair as a parallel word with a valid/ready handshake.
- Sits between the codec ADC pin and the FIR filter input, mirroring the DAC-side serialiser.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_clk_gen.sv | 32 +++
 rtl/i2s_serial_rx.sv | 112 +++++++++++
 tb/tb_i2s_serial_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S receive definitions: FSM states, frame geometry and MSB slot placement.
// I2S_RX_ONE_BIT_DELAY_EN selects Philips framing (MSB one bclk after lrclk edge).
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } rx_state_e;

  localparam int FRAME_LEN = 256;
  localparam int HALF_FRAME = 128;
  localparam int BCLK_DIV = 4;
  localparam logic [1:0] CAPTURE_PHASE = 2'd2;

`ifdef I2S_RX_ONE_BIT_DELAY_EN
  localparam int MSB_SLOT = 1;
`else
  localparam int MSB_SLOT = 0;
`endif

endpackage

// File: rtl/i2s_clk_gen.sv
// Frame counter with bclk/lrclk decode and bclk-rising capture strobe.
// Shared framing block, usable by the DAC-side serialiser as well.
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  output logic [7:0] cnt_o,
  output logic       bclk_o,
  output logic       lrclk_o,
  output logic       strobe_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run_i ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  // Clocks are single flop bits, so they stay glitch-free.
  assign cnt_o    = cnt_q;
  assign bclk_o   = cnt_q[1];
  assign lrclk_o  = cnt_q[7];
  assign strobe_o = run_i && (cnt_q[1:0] == CAPTURE_PHASE);

endmodule

// File: rtl/i2s_serial_rx.sv
// I2S receive master: frames the codec ADC stream and presents L/R pairs via valid/ready.
// Build with I2S_RX_ONE_BIT_DELAY_EN for Philips framing, otherwise left-justified.
module i2s_serial_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk_12M,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sdata_in,
  output logic              bclk,
  output logic              lrclk,
  output logic [DATA_W-1:0] data_left,
  output logic [DATA_W-1:0] data_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam logic [4:0] MSB_K   = 5'(MSB_SLOT);
  localparam logic [4:0] LSB_OFF = 5'(DATA_W - 1);

  rx_state_e state_q, state_d;
  logic [7:0] cnt;
  logic run, strobe, chan_start, in_window, lsb_strobe;
  logic [4:0] offset;
  logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d, shifted;
  logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
  logic valid_q, valid_d, ovf_q, ovf_d;

  i2s_clk_gen u_clk_gen (
    .clk_i   (clk_12M),
    .rst_ni  (rst_n),
    .run_i   (run),
    .cnt_o   (cnt),
    .bclk_o  (bclk),
    .lrclk_o (lrclk),
    .strobe_o(strobe)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = LEFT;
        LEFT:    if (cnt == 8'(HALF_FRAME - 1)) state_d = RIGHT;
        RIGHT:   if (cnt == 8'(FRAME_LEN - 1)) state_d = LEFT;
        default: state_d = IDLE;
      endcase
    end
  end

  assign run = enable && (state_q != IDLE);

  // Modulo-32 offset from the MSB slot puts both window edges in one compare.
  assign offset     = cnt[6:2] - MSB_K;
  assign in_window  = (offset <= LSB_OFF);
  assign lsb_strobe = strobe && (offset == LSB_OFF);
  assign chan_start = run && (cnt[6:0] == 7'd0);
  assign shifted    = (shift_q << 1) | DATA_W'(sdata_in);

  always_comb begin
    shift_d = shift_q;
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (chan_start)               shift_d = '0;
    else if (strobe && in_window) shift_d = shifted;
    if (lsb_strobe && !cnt[7]) hold_d = shifted;
    if (overflow_clr) ovf_d = 1'b0;
    if (valid_q && sample_ready) valid_d = 1'b0;
    // A completing pair overrides both the clear and the acceptance.
    if (lsb_strobe && cnt[7]) begin
      left_d  = hold_q;
      right_d = shifted;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_12M) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_left    = left_q;
  assign data_right   = right_q;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_serial_rx.sv
// Directed bench for i2s_serial_rx: frame table plus enable-drop and reset-abort sequences.
// Honours I2S_RX_ONE_BIT_DELAY_EN to pick the expected slot placement.
module tb_i2s_serial_rx;

  localparam int DATA_W = 24;
`ifdef I2S_RX_ONE_BIT_DELAY_EN
  localparam int MSB_SLOT_TB = 1;
  localparam int VALID_CNT = 227;
`else
  localparam int MSB_SLOT_TB = 0;
  localparam int VALID_CNT = 223;
`endif

  typedef struct {
    logic [23:0] leftWord;
    logic [23:0] rightWord;
    logic        readyAtDone;
    logic        clrAtDone;
    logic        clrAfter;
    logic        acceptAfter;
    logic        expValidBefore;
    logic        expOverflow;
    logic [23:0] expLeft;
    logic [23:0] expRight;
  } frameVec_t;

  logic clk_12M = 1'b0;
  logic rst_n, enable, sdata_in, sample_ready, overflow_clr;
  logic bclk, lrclk, sample_valid, overflow;
  logic [DATA_W-1:0] data_left, data_right;

  logic [7:0] modelCnt;
  logic modelRun;
  logic [23:0] curLeft, curRight;
  int clkErr, totalCount, badCount;
  frameVec_t vecs [6];

  i2s_serial_rx #(.DATA_W(DATA_W)) dut (
    .clk_12M     (clk_12M),
    .rst_n       (rst_n),
    .enable      (enable),
    .sdata_in    (sdata_in),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .data_left   (data_left),
    .data_right  (data_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk_12M = ~clk_12M;

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Codec model: the slot's bit is held from the bclk falling edge; out-of-window slots carry noise.
  task driveCodec();
    logic [23:0] w;
    int idx;
    w = modelCnt[7] ? curRight : curLeft;
    idx = int'(modelCnt[6:2]) - MSB_SLOT_TB;
    if (idx >= 0 && idx < DATA_W) sdata_in = w[DATA_W-1-idx];
    else sdata_in = 1'($urandom_range(0, 1));
  endtask

  task applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_12M);
      if (!rst_n || !enable) begin
        modelRun = 1'b0;
        modelCnt = 8'd0;
      end else if (!modelRun) begin
        modelRun = 1'b1;
      end else begin
        modelCnt = modelCnt + 8'd1;
      end
      #1;
      driveCodec();
      if (bclk !== modelCnt[1] || lrclk !== modelCnt[7]) clkErr++;
    end
  endtask

  task waitForCnt(input logic [7:0] target);
    for (int n = 0; n < 300 && modelCnt != target; n++) applyStimulus(1);
    if (modelCnt != target) checkOutput("cnt wait timeout", 32'(modelCnt), 32'(target));
  endtask

  task waitForValid(input string name, input int expectedTicks);
    int n;
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (!sample_valid && n < 400);
    checkOutput(name, n, expectedTicks);
  endtask

  task checkAllZero(input string tag);
    checkOutput({tag, " bclk"}, 32'(bclk), 0);
    checkOutput({tag, " lrclk"}, 32'(lrclk), 0);
    checkOutput({tag, " data_left"}, 32'(data_left), 0);
    checkOutput({tag, " data_right"}, 32'(data_right), 0);
    checkOutput({tag, " valid"}, 32'(sample_valid), 0);
    checkOutput({tag, " overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    totalCount = 0;
    badCount = 0;
    clkErr = 0;
    modelCnt = 8'd0;
    modelRun = 1'b0;
    curLeft = 24'h0;
    curRight = 24'h0;
    rst_n = 1'b0;
    enable = 1'b0;
    sdata_in = 1'b0;
    sample_ready = 1'b0;
    overflow_clr = 1'b0;

    vecs[0] = '{24'h123456, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, 24'hABCDEF};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 24'h7FFFFF};
    vecs[2] = '{24'h111111, 24'h222222, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h111111, 24'h222222};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF, 24'h000001};
    vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'hFFFFFF};
    vecs[5] = '{24'h5A5A5A, 24'hA5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h5A5A5A, 24'hA5A5A5};

    applyStimulus(3);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(2);
    enable = 1'b1;
    applyStimulus(1);

    // Each record spans one frame starting at cnt=0.
    for (int i = 0; i < 6; i++) begin
      curLeft = vecs[i].leftWord;
      curRight = vecs[i].rightWord;
      driveCodec();
      waitForCnt(8'(VALID_CNT - 1));
      checkOutput($sformatf("vec%0d valid before done", i), 32'(sample_valid), 32'(vecs[i].expValidBefore));
      sample_ready = vecs[i].readyAtDone;
      overflow_clr = vecs[i].clrAtDone;
      applyStimulus(1);
      sample_ready = 1'b0;
      overflow_clr = 1'b0;
      checkOutput($sformatf("vec%0d valid", i), 32'(sample_valid), 1);
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOverflow));
      checkOutput($sformatf("vec%0d data_left", i), 32'(data_left), 32'(vecs[i].expLeft));
      checkOutput($sformatf("vec%0d data_right", i), 32'(data_right), 32'(vecs[i].expRight));
      if (vecs[i].clrAfter) begin
        overflow_clr = 1'b1;
        applyStimulus(1);
        overflow_clr = 1'b0;
        checkOutput($sformatf("vec%0d overflow cleared", i), 32'(overflow), 0);
        checkOutput($sformatf("vec%0d valid after clear", i), 32'(sample_valid), 1);
      end
      if (vecs[i].acceptAfter) begin
        sample_ready = 1'b1;
        applyStimulus(1);
        sample_ready = 1'b0;
        checkOutput($sformatf("vec%0d valid after accept", i), 32'(sample_valid), 0);
      end
      waitForCnt(8'd0);
      checkOutput($sformatf("vec%0d clock decode errors", i), clkErr, 0);
      clkErr = 0;
    end

    // Enable dropped mid-frame: clocks stop, pending pair retained.
    waitForCnt(8'd150);
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("disable bclk", 32'(bclk), 0);
    checkOutput("disable lrclk", 32'(lrclk), 0);
    checkOutput("disable data_left", 32'(data_left), 32'h5A5A5A);
    checkOutput("disable data_right", 32'(data_right), 32'hA5A5A5);
    checkOutput("disable valid", 32'(sample_valid), 1);
    checkOutput("disable overflow", 32'(overflow), 0);
    sample_ready = 1'b1;
    applyStimulus(1);
    sample_ready = 1'b0;
    checkOutput("disable accept", 32'(sample_valid), 0);
    applyStimulus(5);
    curLeft = 24'h0F0F0F;
    curRight = 24'hF0F0F0;
    enable = 1'b1;
    waitForValid("re-enable latency", VALID_CNT + 1);
    checkOutput("re-enable data_left", 32'(data_left), 32'h0F0F0F);
    checkOutput("re-enable data_right", 32'(data_right), 32'hF0F0F0);

    // Reset mid-frame aborts the frame in progress.
    waitForCnt(8'd62);
    curLeft = 24'h333333;
    curRight = 24'h444444;
    rst_n = 1'b0;
    applyStimulus(1);
    checkAllZero("mid-frame reset");
    rst_n = 1'b1;
    waitForValid("post-reset latency", VALID_CNT + 1);
    checkOutput("post-reset data_left", 32'(data_left), 32'h333333);
    checkOutput("post-reset data_right", 32'(data_right), 32'h444444);
    checkOutput("final clock decode errors", clkErr, 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
